uart_rx_os16: RTL
=================

# uart_rx_os16

Receive half of the 8-bit UART: 8 data bits, no parity, 1 stop bit, LSB first. It is the counterpart of the team's transmit-only UART and uses the same style of external baud strobe. Here the strobe is 16× the bit rate rather than 1×. The block recovers bytes from the asynchronous `rxd` line into a one-byte holding register and reports status with `ready`, `frame_err` and `overrun`.

## Interface
- `OVERSAMPLE`, default 16: sample ticks per bit; must be even and ≥4.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `sample`  in  1  one-clock pulse at `OVERSAMPLE`× the baud rate.
- `rxd`  in  1  serial input, asynchronous to `clock`, idles high.
- `rd`  in  1  one-clock read strobe; acknowledges the holding register.
- `dout`  out  8  holding register; last good byte.
- `ready`  out  1  1 = unread byte in `dout`.
- `frame_err`  out  1  sticky: stop bit sampled 0.
- `overrun`  out  1  sticky: a byte completed while `ready` = 1.
- `CS`  out  2  current state: IDLE=0, START=1, DATA=2, STOP=3.

## Operation
- **Synchronizer:** `rxd` passes through a 2-flop synchronizer, reset value 1. `rxd_s` is the synchronized value.
- **Counters:**
  - `tick_cnt` is log2(`OVERSAMPLE`) bits wide and advances only on `sample`.
  - `bit_cnt` is 3 bits wide.
  - The shift register `sr[7:0]` shifts right; each new bit enters at `sr[7]`.
- **`armed` flag:** set in IDLE on any tick with `rxd_s` = 1; cleared on leaving IDLE. A line held low (break) therefore never retriggers reception.
- **IDLE:** on a tick with `armed` = 1 and `rxd_s` = 0, go to START with `tick_cnt` = 0.
- **START:** on each tick, `tick_cnt`++.
  - When `tick_cnt` = `OVERSAMPLE`/2−1 (7) on a tick, check `rxd_s`.
  - `rxd_s` = 0: go to DATA with `tick_cnt` = 0 and `bit_cnt` = 0.
  - `rxd_s` = 1: false start; return to IDLE. No flags change.
- **DATA:** on each tick, `tick_cnt`++.
  - When `tick_cnt` = `OVERSAMPLE`−1 (15) on a tick: `sr` ← {`rxd_s`, `sr[7:1]`}, `tick_cnt` ← 0, `bit_cnt`++.
  - After the sample with `bit_cnt` = 7, go to STOP.
- **STOP:** at `tick_cnt` = 15 on a tick, sample `rxd_s` and go to IDLE.
  - `rxd_s` = 1: `dout` ← `sr`, `ready` ← 1. If `ready` was already 1 and `rd` is not asserted this clock, `overrun` ← 1. The new byte overwrites the old one.
  - `rxd_s` = 0: `frame_err` ← 1; `dout` and `ready` are unchanged.
- **`rd` = 1:** clears `ready`, `frame_err` and `overrun` on the next edge.
- **Simultaneous events:** `rd` in the same clock as a byte completing:
  - `ready` stays 1 and `dout` takes the new byte.
  - `overrun` is not set.
  - `frame_err` is cleared, unless the completing byte itself has a framing error, in which case it is set.
- **Reset:** forces IDLE at any point, including mid-byte. The partial byte is discarded. `armed` = 0, so a line still low after reset is ignored until it has been seen high.
- **Invalid state:** returns to IDLE on the next edge.

## Timing
- **Reset values:** `dout` = 0x00, `ready` = 0, `frame_err` = 0, `overrun` = 0, `CS` = 0; internal `sr` = 0, both counters 0.
- **Synchronizer latency:** 2 clocks from `rxd` to `rxd_s`.
- **Sample points:** the start bit is re-checked half a bit after detection; each data bit and the stop bit are sampled one bit-time later, at nominal mid-bit.
- **Output latency:** `ready`, `frame_err` and `overrun` update on the same edge that takes the stop sample.
- **Back-to-back frames:** the block returns to IDLE at mid-stop bit. A start bit immediately following the stop bit is detected.
- **Clock tolerance:** total timing error of about ±4.5% is tolerated across the frame.
- **`sample` held high:** every clock counts as a tick; this is legal and used for fast simulation.

## Structure
- **`uart_pkg`:**
  - state encodings IDLE, START, DATA and STOP;
  - the default `OVERSAMPLE`;
  - data width 8.
- **Sub-module `uart_sync2`:** the 2-flop synchronizer with a parameterized reset value. It is reusable by other asynchronous inputs.
- **Remaining logic:** FSM, counters, shift register and status flags live in the top file.

## Test plan
- **Clean byte:** `sample` every 4 clocks; frame 0xA5 sent at 16 ticks/bit → `ready` = 1, `dout` = 0xA5, `frame_err` = `overrun` = 0; `rd` pulse → `ready` = 0.
- **False start:** `rxd` glitches low for 4 ticks → `CS` goes 1 then back to 0; `ready` stays 0 and `dout` is unchanged.
- **Framing error:** 0x3C sent with stop bit = 0 → `frame_err` = 1, `ready` = 0, `dout` keeps its prior 0xA5. A subsequent break held low for 40 ticks causes no further start.
- **Overrun:** 0x11 then 0x22 sent back-to-back with no `rd` → `dout` = 0x22, `ready` = 1, `overrun` = 1. One `rd` clears both flags.
- **Coincident read:** `rd` asserted on the stop-sample clock of 0x5A → `dout` = 0x5A, `ready` = 1, `overrun` = 0.
- **Reset mid-byte:** `reset` pulsed during DATA bit 4 → all outputs at reset values immediately. The next clean 0xC3 is received correctly after `rxd` has been seen high.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encodings, default
// oversampling ratio and data width.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_W         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so idle-high and idle-low lines can both use it.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver driven by an external oversampling strobe; recovers bytes
// into a one-byte holding register with ready / frame_err / overrun status.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample,
    input  logic              rxd,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              ready,
    output logic              frame_err,
    output logic              overrun,
    output logic [1:0]        CS
);

    localparam int            TW     = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    uart_state_e       state, state_nxt;
    logic [TW-1:0]     tick_cnt, tick_nxt;
    logic [2:0]        bit_cnt, bit_nxt;
    logic [DATA_W-1:0] sr, sr_nxt;
    logic              armed, armed_nxt;
    logic              rxd_s;
    logic              stop_ok, stop_bad;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rxd),
        .q     (rxd_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            sr       <= sr_nxt;
            armed    <= armed_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        sr_nxt    = sr;
        armed_nxt = 1'b0;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                // A start edge only counts once the line has been seen high.
                armed_nxt = armed;
                if (sample) begin
                    if (rxd_s) begin
                        armed_nxt = 1'b1;
                    end else if (armed) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                        armed_nxt = 1'b0;
                    end
                end
            end
            START: begin
                if (sample) begin
                    if (tick_cnt == T_HALF) begin
                        tick_nxt = '0;
                        if (rxd_s) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DATA;
                            bit_nxt   = '0;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    if (tick_cnt == T_LAST) begin
                        sr_nxt   = {rxd_s, sr[DATA_W-1:1]};
                        tick_nxt = '0;
                        bit_nxt  = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_nxt = STOP;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
            end
            STOP: begin
                if (sample) begin
                    if (tick_cnt == T_LAST) begin
                        state_nxt = IDLE;
                        tick_nxt  = '0;
                        stop_ok   = rxd_s;
                        stop_bad  = ~rxd_s;
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tick_nxt  = '0;
            end
        endcase
    end

    // A read in the same clock as a completing byte clears the old status
    // first; the completing byte's own outcome then takes precedence.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout      <= '0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (rd) begin
                ready     <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            if (stop_ok) begin
                dout  <= sr;
                ready <= 1'b1;
                if (ready && !rd) begin
                    overrun <= 1'b1;
                end
            end
            if (stop_bad) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign CS = state;

endmodule
